imm_encoder: RTL
================

# imm_encoder

Pipelined immediate packer for the RV32I pipeline processor; it performs the inverse of the decode-side immediate extender. It takes an instruction template (opcode, registers and function fields, with the immediate bits ignored), an immediate-format select and a 32-bit immediate, and scatters the immediate into the RISC-V I/S/B/J bit positions. Each packed word is emitted through a valid/ready handshake with a sequential instruction-memory word address and a per-word range-error flag. It sits in the program-loader path in front of instruction memory, and in the bench as a stimulus generator.

## Interface
- ADDR_W, 8, width of the instruction-memory word address counter
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush and restart: empties the pipe, addr to 0, clears err_sticky
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- ImmSrc  input  2  immediate format: 00 I, 01 S, 10 B, 11 J
- base  input  32  instruction template; bits owned by the selected format are overwritten
- ImmVal  input  32  immediate value, two's complement
- out_valid  output  1  instr/addr/range_err valid
- out_ready  input  1  consumer accepts when out_valid && out_ready
- instr  output  32  packed instruction word
- addr  output  ADDR_W  word address assigned to the current output word
- range_err  output  1  current word's immediate did not fit its format
- err_sticky  output  1  set by any range_err handshake; cleared only by reset or clear

## Operation
- Two register stages, S1 and S2, each with its own valid bit.
- **S1 (capture):** registers ImmSrc, base and ImmVal, and computes the range check.
- **S2 (output):** holds the packed instr and the registered range_err.
- **Packing** (imm = ImmVal; all other base bits pass through unchanged):
  - I: instr[31:20]=imm[11:0].
  - S: instr[31:25]=imm[11:5], instr[11:7]=imm[4:0].
  - B: instr[31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: instr[31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- **Range check:**
  - I and S: ImmVal[31:11] all equal.
  - B: ImmVal[31:12] all equal and ImmVal[0]==0.
  - J: ImmVal[31:20] all equal and ImmVal[0]==0.
- **Range failure:** the word is still emitted, with truncated bits as packed above. range_err=1 accompanies it, and err_sticky sets on its output handshake.
- **Round-trip property:** when range_err=0, decode-extending instr[31:7] with the same ImmSrc reproduces ImmVal exactly.
- **Address:** addr starts at 0 and increments by 1 on each output handshake. It wraps from 2^ADDR_W-1 to 0 without error.
- **Clear:**
  - Highest priority: overrides any same-cycle input or output handshake.
  - Drops both valid bits; any in-flight word is discarded and not counted.
  - Sets addr to 0 and err_sticky to 0.
  - in_ready=0 while clear=1.

## Timing
- **Reset values:** out_valid=0, instr=0, addr=0, range_err=0, err_sticky=0, both stage valid bits 0. in_ready=1 once rst_n is high, since the pipe is empty.
- **Latency:** a word accepted in cycle N appears with out_valid=1 in cycle N+2 if there is no backpressure.
- **Throughput:** one word per cycle sustained.
- **Stage advance:**
  - S2 loads when S2 is empty or out_ready=1.
  - S1 advances when S1 is valid and S2 loads.
  - in_ready = !clear && (!S1.valid || S2 loads). in_ready is combinational from out_ready; no skid buffer is used.
- **Output stability:** while out_valid=1 and out_ready=0, instr, addr and range_err are held stable.
- **Capacity under stall:** with out_ready held low, at most 2 words are held internally, then in_ready=0. No word is dropped or duplicated.
- **Empty pipe:** out_valid stays 0 and addr holds.
- **Reset mid-operation:** asserting rst_n low asynchronously clears all state. Partially packed words are lost.

## Test plan
- **I-type:** base=0x00000093, ImmSrc=00, ImmVal=0xFFFFFFFF -> instr=0xFFF00093, range_err=0, addr=0, out_valid exactly 2 cycles after acceptance.
- **S/B/J back-to-back:**
  - S: base=0x0020A023, ImmVal=8 -> 0x0020A423, addr=0.
  - B: base=0x00000063, ImmVal=0xFFFFFFFC -> 0xFE000EE3, addr=1.
  - J: base=0x000000EF, ImmVal=0x800 -> 0x001000EF, addr=2.
  - One word per cycle with out_ready=1.
- **Range errors:**
  - I with ImmVal=0x00000800 -> instr[31:20]=0x800, range_err=1, err_sticky=1 after handshake.
  - B with ImmVal=0x00000003 -> range_err=1.
  - I with ImmVal=0x7FF -> range_err=0.
- **Backpressure:** hold out_ready=0 while offering 4 words -> 2 accepted, then in_ready=0. Release -> all 4 emitted in order, addr 0..3, contents and addr stable during stall.
- **Wrap:** ADDR_W=2, 5 words -> addr sequence 0,1,2,3,0.
- **Clear:** assert clear for 1 cycle with 2 words in flight and out_ready=0 -> out_valid=0 next cycle, addr=0, err_sticky=0. Next accepted word gets addr 0.
- **Reset:** drop rst_n mid-stream -> all outputs immediately return to reset values.

Source files
------------

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage RV32I immediate packer with addressed valid/ready output and range-error flags
module imm_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ImmSrc,
  input  logic [31:0]       base,
  input  logic [31:0]       ImmVal,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] addr,
  output logic              range_err,
  output logic              err_sticky
);
  logic        s1_v, s1_err, s2_load, fit, fit_i, fit_b, fit_j;
  logic [1:0]  s1_src;
  logic [24:0] s1_base;
  logic [20:0] s1_imm;
  logic [31:0] packed_w;
  always_comb begin
    fit_i    = &ImmVal[31:11] | ~|ImmVal[31:11];
    fit_b    = (&ImmVal[31:12] | ~|ImmVal[31:12]) & ~ImmVal[0];
    fit_j    = (&ImmVal[31:20] | ~|ImmVal[31:20]) & ~ImmVal[0];
    fit      = ImmSrc[1] ? (ImmSrc[0] ? fit_j : fit_b) : fit_i;
    s2_load  = !out_valid || out_ready;
    in_ready = !clear && (!s1_v || s2_load);
    packed_w = s1_src == 2'd0 ? {s1_imm[11:0], s1_base[19:0]} :
               s1_src == 2'd1 ? {s1_imm[11:5], s1_base[24:12], s1_imm[4:0], s1_base[6:0]} :
               s1_src == 2'd2 ? {s1_imm[12], s1_imm[10:5], s1_base[24:12], s1_imm[4:1], s1_imm[11], s1_base[6:0]} :
                                {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_base[11:0]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v       <= 1'b0;
      s1_err     <= 1'b0;
      s1_src     <= '0;
      s1_base    <= '0;
      s1_imm     <= '0;
      out_valid  <= 1'b0;
      instr      <= '0;
      addr       <= '0;
      range_err  <= 1'b0;
      err_sticky <= 1'b0;
    end else if (clear) begin
      s1_v       <= 1'b0;
      out_valid  <= 1'b0;
      addr       <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        s1_v    <= 1'b1;
        s1_err  <= !fit;
        s1_src  <= ImmSrc;
        s1_base <= base[24:0];
        s1_imm  <= ImmVal[20:0];
      end else if (s2_load) begin
        s1_v <= 1'b0;
      end
      if (s2_load) begin
        out_valid <= s1_v;
        if (s1_v) begin
          instr     <= packed_w;
          range_err <= s1_err;
        end
      end
      if (out_valid && out_ready) begin
        addr <= addr + 1'b1;
        if (range_err) err_sticky <= 1'b1;
      end
    end
  end
endmodule
